// File: rtl/ct_byte_packer.sv
// ct_byte_packer
// Streams a compressed ML-KEM ciphertext out of the polynomial bank as bytes.
// It reads u[0..K-1] and then v through the bank host port. Each coefficient
// is bit-packed LSB-first, using DU bits for u and DV bits for v. The packed
// bytes leave on a valid/ready stream.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, abort    one-cycle control pulses (abort wins over start)
//   busy, done      busy while packing; done pulses after the final byte
//   rd_slot/addr    bank host-port address, zero whenever idle
//   rd_data         bank read data, valid RD_LAT cycles after the address
//   out_valid/data  registered byte stream
//   out_last        flags the final ciphertext byte
//   out_ready       downstream acceptance
module ct_byte_packer #(
   parameter int K      = 3,
   parameter int DU     = 10,
   parameter int DV     = 4,
   parameter int U_BASE = 16,
   parameter int V_SLOT = 19,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_slot,
   output logic [7:0]  rd_addr,
   input  logic [11:0] rd_data,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        out_ready
);

   localparam int TOTAL = 32 * (K * DU + DV);
   localparam int ACC_W = 18;
   localparam int BC_W  = 11;
   localparam logic [11:0]     MASK_U      = 12'((1 << DU) - 1);
   localparam logic [11:0]     MASK_V      = 12'((1 << DV) - 1);
   localparam logic [4:0]      LAST_U_SLOT = 5'(U_BASE + K - 1);
   localparam logic [4:0]      V_SLOT_L    = 5'(V_SLOT);
   localparam logic [4:0]      U_BASE_L    = 5'(U_BASE);
   localparam logic [1:0]      LAT_LAST    = 2'(RD_LAT - 1);
   localparam logic [BC_W-1:0] LAST_BYTE   = BC_W'(TOTAL - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_EMIT,
      ST_FIN
   } state_t;

   state_t state, state_next;

   logic             is_v;
   logic [ACC_W-1:0] acc;
   logic [4:0]       bit_cnt;
   logic [1:0]       lat_cnt;
   logic [BC_W-1:0]  byte_cnt;

   logic             slot_free;
   logic             have_byte;
   logic             lat_done;
   logic             last_coef;
   logic [4:0]       cur_d;
   logic [ACC_W-1:0] coef_ext;

   // The output register can take a new byte when it is empty or is being
   // accepted this cycle; this allows back-to-back bytes.
   assign slot_free = !out_valid || out_ready;
   assign have_byte = bit_cnt >= 5'd8;
   assign lat_done  = lat_cnt == LAT_LAST;
   assign last_coef = is_v && (rd_addr == 8'd255);
   assign cur_d     = is_v ? 5'(DV) : 5'(DU);
   assign coef_ext  = {{(ACC_W-12){1'b0}}, rd_data & (is_v ? MASK_V : MASK_U)};

   assign busy = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_EMIT);
   assign done = (state == ST_FIN);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Abort overrides everything, including a start
   // in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_FETCH;
         ST_FETCH: state_next = ST_WAIT;
         ST_WAIT:  if (lat_done) state_next = ST_EMIT;
         ST_EMIT:  if (slot_free && !have_byte) state_next = last_coef ? ST_FIN : ST_FETCH;
         ST_FIN:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (abort) state_next = ST_IDLE;
   end

   // Datapath. rd_slot/rd_addr double as the coefficient walk counters, so
   // they sit at zero in idle and hold steady through fetch/wait/emit.
   // A coefficient is only advanced once the output register is empty (or
   // draining), so no byte from the old coefficient is ever lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_slot   <= '0;
         rd_addr   <= '0;
         is_v      <= 1'b0;
         acc       <= '0;
         bit_cnt   <= '0;
         lat_cnt   <= '0;
         byte_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (abort) begin
         rd_slot   <= '0;
         rd_addr   <= '0;
         is_v      <= 1'b0;
         acc       <= '0;
         bit_cnt   <= '0;
         lat_cnt   <= '0;
         byte_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rd_slot  <= U_BASE_L;
                  rd_addr  <= '0;
                  is_v     <= 1'b0;
                  acc      <= '0;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
               end
            end
            ST_FETCH: begin
               lat_cnt <= '0;
            end
            ST_WAIT: begin
               if (lat_done) begin
                  acc     <= acc | (coef_ext << bit_cnt);
                  bit_cnt <= bit_cnt + cur_d;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            ST_EMIT: begin
               if (slot_free) begin
                  if (have_byte) begin
                     out_valid <= 1'b1;
                     out_data  <= acc[7:0];
                     out_last  <= (byte_cnt == LAST_BYTE);
                     acc       <= acc >> 8;
                     bit_cnt   <= bit_cnt - 5'd8;
                     byte_cnt  <= byte_cnt + 1'b1;
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (last_coef) begin
                        rd_slot <= '0;
                        rd_addr <= '0;
                        is_v    <= 1'b0;
                     end else if (rd_addr == 8'd255) begin
                        rd_addr <= '0;
                        if (rd_slot == LAST_U_SLOT) begin
                           rd_slot <= V_SLOT_L;
                           is_v    <= 1'b1;
                        end else begin
                           rd_slot <= rd_slot + 5'd1;
                        end
                     end else begin
                        rd_addr <= rd_addr + 8'd1;
                     end
                  end
               end
            end
            ST_FIN: begin
               byte_cnt <= '0;
            end
            default: begin
               byte_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ct_byte_packer.sv
// tb_ct_byte_packer
// Drives two packer instances from a shared bank model:
//   - inst a: defaults (K=3, DU=10, DV=4, RD_LAT=1)
//   - inst b: K=4, DU=11, DV=5, RD_LAT=2, with v at slot 20
// Received bytes are compared against a bit-serial ByteEncode model and
// hand-computed byte values.
module tb_ct_byte_packer;

   logic clk = 1'b0;
   logic rst, start, abort, out_ready;
   logic sel, rand_ready;

   always #5 clk = ~clk;

   logic        a_busy, a_done, a_valid, a_last;
   logic [4:0]  a_slot;
   logic [7:0]  a_addr, a_data;
   logic [11:0] a_rd;
   logic        b_busy, b_done, b_valid, b_last;
   logic [4:0]  b_slot;
   logic [7:0]  b_addr, b_data;
   logic [11:0] b_rd, b_p;

   logic [11:0] mem [0:31][0:255];

   ct_byte_packer dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(a_busy), .done(a_done), .rd_slot(a_slot), .rd_addr(a_addr),
      .rd_data(a_rd), .out_valid(a_valid), .out_data(a_data),
      .out_last(a_last), .out_ready(out_ready)
   );

   ct_byte_packer #(.K(4), .DU(11), .DV(5), .U_BASE(16), .V_SLOT(20), .RD_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(b_busy), .done(b_done), .rd_slot(b_slot), .rd_addr(b_addr),
      .rd_data(b_rd), .out_valid(b_valid), .out_data(b_data),
      .out_last(b_last), .out_ready(out_ready)
   );

   // Bank read ports with one and two cycles of latency.
   always @(posedge clk) a_rd <= mem[a_slot][a_addr];
   always @(posedge clk) begin
      b_p  <= mem[b_slot][b_addr];
      b_rd <= b_p;
   end

   logic       cur_valid, cur_last, cur_done, cur_busy;
   logic [7:0] cur_data;
   logic [4:0] cur_slot;
   assign cur_valid = sel ? b_valid : a_valid;
   assign cur_last  = sel ? b_last  : a_last;
   assign cur_done  = sel ? b_done  : a_done;
   assign cur_busy  = sel ? b_busy  : a_busy;
   assign cur_data  = sel ? b_data  : a_data;
   assign cur_slot  = sel ? b_slot  : a_slot;

   int nvec = 0;
   int nfail = 0;

   logic [7:0] got [0:2047];
   logic [7:0] exp_b [0:2047];
   int got_n, exp_len, last_cnt, last_idx, done_cnt;
   logic prev_stall;
   logic [7:0] prev_data;
   logic prev_last;

   // Downstream: always ready, or ready about 60% of cycles.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
      end
   end

   // Monitor on the falling edge: records accepted bytes, done pulses and
   // checks that a stalled byte holds still.
   always @(negedge clk) begin
      if (prev_stall) begin
         nvec++;
         if (!(cur_valid && cur_data == prev_data && cur_last == prev_last)) begin
            nfail++;
            $display("[TB] FAIL hold: got valid=%0b data=%02h, expected valid=1 data=%02h", cur_valid, cur_data, prev_data);
         end
      end
      if (cur_valid && out_ready) begin
         if (got_n < 2048) got[got_n] = cur_data;
         if (cur_last) begin
            last_cnt++;
            last_idx = got_n;
         end
         got_n++;
      end
      if (cur_done) done_cnt++;
      prev_stall = cur_valid && !out_ready;
      prev_data  = cur_data;
      prev_last  = cur_last;
   end

   task automatic check_output(input string name, input int act, input int expv);
      nvec++;
      if (act != expv) begin
         nfail++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
      end
   endtask

   task automatic clear_mon();
      got_n = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; prev_stall = 1'b0;
   endtask

   task automatic apply_stimulus();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic build_model(input int k, input int du, input int dv, input int vslot);
      logic [63:0] acc;
      int bits, slot, d;
      acc = '0; bits = 0; exp_len = 0;
      for (int s = 0; s <= k; s++) begin
         slot = (s < k) ? 16 + s : vslot;
         d    = (s < k) ? du : dv;
         for (int a = 0; a < 256; a++) begin
            acc = acc | ((64'(mem[slot][a]) & ((64'd1 << d) - 64'd1)) << bits);
            bits += d;
            while (bits >= 8) begin
               exp_b[exp_len] = acc[7:0];
               exp_len++;
               acc = acc >> 8;
               bits -= 8;
            end
         end
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt == 0) check_output({name, " done_timeout"}, 0, 1);
   endtask

   task automatic wait_bytes(input string name, input int target);
      int n = 0;
      while (got_n < target && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (got_n < target) check_output({name, " byte_timeout"}, got_n, target);
   endtask

   task automatic check_stream(input string name);
      int bad = 0;
      for (int i = 0; i < exp_len; i++)
         if (i >= got_n || got[i] !== exp_b[i]) bad++;
      check_output({name, " stream_bad_bytes"}, bad, 0);
      check_output({name, " length"}, got_n, exp_len);
   endtask

   task automatic run_full(input string name);
      clear_mon();
      apply_stimulus();
      wait_done(name);
      repeat (2) @(posedge clk);
      #1;
      check_output({name, " done_pulses"}, done_cnt, 1);
      check_output({name, " busy_after"}, int'(cur_busy), 0);
      check_output({name, " last_count"}, last_cnt, 1);
      check_output({name, " last_index"}, last_idx, exp_len - 1);
      check_stream(name);
   endtask

   task automatic clear_mem();
      for (int s = 0; s < 32; s++)
         for (int a = 0; a < 256; a++)
            mem[s][a] = 12'h000;
   endtask

   task automatic random_mem();
      for (int s = 0; s < 32; s++)
         for (int a = 0; a < 256; a++)
            mem[s][a] = 12'($urandom);
   endtask

   typedef struct {
      int          s0, a0;
      logic [11:0] v0;
      int          s1, a1;
      logic [11:0] v1;
      int          i0;
      logic [7:0]  e0;
      int          i1;
      logic [7:0]  e1;
      int          i2;
      logic [7:0]  e2;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int exp1408;
      vecs[0] = '{16, 0, 12'h000, 16, 0, 12'h000, 0, 8'h00, 500, 8'h00, 1087, 8'h00};
      vecs[1] = '{16, 0, 12'h3FF, 16, 1, 12'h001, 0, 8'hFF, 1, 8'h07, 2, 8'h00};
      vecs[2] = '{19, 0, 12'h005, 19, 1, 12'h00A, 960, 8'hA5, 959, 8'h00, 961, 8'h00};
      vecs[3] = '{16, 0, 12'hFFF, 16, 0, 12'hFFF, 0, 8'hFF, 1, 8'h03, 2, 8'h00};
      vecs[4] = '{18, 255, 12'h3FF, 18, 255, 12'h3FF, 958, 8'hC0, 959, 8'hFF, 960, 8'h00};
      vecs[5] = '{17, 0, 12'h2AB, 17, 0, 12'h2AB, 319, 8'h00, 320, 8'hAB, 321, 8'h02};

      rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; rand_ready = 1'b0;
      clear_mon();
      clear_mem();
      repeat (3) @(posedge clk);
      #1;
      check_output("reset busy", int'(a_busy), 0);
      check_output("reset done", int'(a_done), 0);
      check_output("reset out_valid", int'(a_valid), 0);
      check_output("reset out_data", int'(a_data), 0);
      check_output("reset out_last", int'(a_last), 0);
      check_output("reset rd_slot", int'(a_slot), 0);
      check_output("reset rd_addr", int'(a_addr), 0);
      rst = 1'b0;

      // Directed vectors on the default instance, restarting after each done.
      for (int v = 0; v < 6; v++) begin
         clear_mem();
         mem[vecs[v].s0][vecs[v].a0] = vecs[v].v0;
         mem[vecs[v].s1][vecs[v].a1] = vecs[v].v1;
         build_model(3, 10, 4, 19);
         run_full($sformatf("vec%0d", v));
         check_output($sformatf("vec%0d byte%0d", v, vecs[v].i0), int'(got[vecs[v].i0]), int'(vecs[v].e0));
         check_output($sformatf("vec%0d byte%0d", v, vecs[v].i1), int'(got[vecs[v].i1]), int'(vecs[v].e1));
         check_output($sformatf("vec%0d byte%0d", v, vecs[v].i2), int'(got[vecs[v].i2]), int'(vecs[v].e2));
      end

      // Random bank, with and without back-pressure.
      random_mem();
      build_model(3, 10, 4, 19);
      rand_ready = 1'b1;
      run_full("rand_backpressure");
      rand_ready = 1'b0;
      run_full("rand_full_ready");

      // Abort after byte 500, then a clean restart.
      clear_mon();
      apply_stimulus();
      wait_bytes("abort", 500);
      #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      check_output("abort out_valid", int'(cur_valid), 0);
      check_output("abort busy", int'(cur_busy), 0);
      check_output("abort rd_slot", int'(cur_slot), 0);
      repeat (5) @(posedge clk);
      #1;
      check_output("abort done_pulses", done_cnt, 0);
      run_full("after_abort");

      // Asynchronous reset mid-stream, then a clean restart.
      clear_mon();
      apply_stimulus();
      wait_bytes("reset_mid", 300);
      #1; rst = 1'b1;
      #1;
      check_output("rst_mid out_valid", int'(cur_valid), 0);
      check_output("rst_mid busy", int'(cur_busy), 0);
      check_output("rst_mid rd_addr", int'(a_addr), 0);
      @(posedge clk); #1; rst = 1'b0;
      run_full("after_reset");

      // Start and abort together: abort wins.
      clear_mon();
      @(posedge clk); #1; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
      check_output("start_abort busy", int'(cur_busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check_output("start_abort busy_later", int'(cur_busy), 0);
      check_output("start_abort bytes", got_n, 0);

      // A start while busy must not disturb the stream.
      clear_mon();
      apply_stimulus();
      wait_bytes("start_busy", 100);
      #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done("start_busy");
      repeat (2) @(posedge clk);
      #1;
      check_output("start_busy done_pulses", done_cnt, 1);
      check_stream("start_busy");

      // K=4 / DU=11 / DV=5 / RD_LAT=2 instance.
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      sel = 1'b1;
      random_mem();
      build_model(4, 11, 5, 20);
      check_output("k4 model length", exp_len, 1568);
      rand_ready = 1'b1;
      run_full("k4");
      rand_ready = 1'b0;
      exp1408 = int'(mem[20][0] & 12'h01F) | (int'(mem[20][1] & 12'h007) << 5);
      check_output("k4 byte1408", int'(got[1408]), exp1408);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
